// File: rtl/tlr_pkg.sv
// Shared types and helpers for the thick-line rasteriser: FSM states, screen
// defaults, internal coordinate width and the on-screen test used for clipping.
package tlr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PIXEL,
    S_ADVANCE
  } state_e;

  localparam int DEF_H_RES       = 320;
  localparam int DEF_V_RES       = 240;
  localparam int DEF_PIXEL_BYTES = 2;

  // Two spare bits let span offsets go negative or past the edge without wrapping.
  function automatic int coord_width(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

  localparam int DEF_COORD_W = coord_width(9, 8);

  function automatic logic on_screen(input int x, input int y,
                                     input int h_res, input int v_res);
    return (x >= 0) && (x < h_res) && (y >= 0) && (y < v_res);
  endfunction

endpackage

// File: rtl/tlr_bresenham_stepper.sv
// Bresenham centre-line walker: holds the major/minor position and error term,
// loaded once per line and stepped once per major-axis advance.
module tlr_bresenham_stepper #(
  parameter int W = 11
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                step,
  input  logic signed [W-1:0] maj_start,
  input  logic signed [W-1:0] maj_end,
  input  logic signed [W-1:0] min_start,
  input  logic signed [W-1:0] min_end,
  output logic signed [W-1:0] maj,
  output logic signed [W-1:0] min,
  output logic                at_end
);

  localparam logic signed [W-1:0] ONE = W'(1);

  logic signed [W-1:0] maj_q, maj_d, min_q, min_d, end_q, end_d;
  logic signed [W-1:0] dmaj_q, dmaj_d, dmin_q, dmin_d, min_diff;
  logic signed [W:0]   err_q, err_d, err_sum;
  logic                ystep_neg_q, ystep_neg_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    maj_d       = maj_q;
    min_d       = min_q;
    end_d       = end_q;
    dmaj_d      = dmaj_q;
    dmin_d      = dmin_q;
    err_d       = err_q;
    ystep_neg_d = ystep_neg_q;
    min_diff    = min_end - min_start;
    err_sum     = err_q + $signed({dmin_q[W-1], dmin_q});

    if (load) begin
      maj_d       = maj_start;
      min_d       = min_start;
      end_d       = maj_end;
      dmaj_d      = maj_end - maj_start;
      dmin_d      = min_diff[W-1] ? -min_diff : min_diff;
      ystep_neg_d = !(min_end > min_start);
      err_d       = -$signed({2'b00, dmaj_d[W-1:1]});
    end else if (step) begin
      maj_d = maj_q + ONE;
      // Strictly positive error moves the minor axis one step.
      if (!err_sum[W] && (err_sum != '0)) begin
        min_d = ystep_neg_q ? (min_q - ONE) : (min_q + ONE);
        err_d = err_sum - $signed({dmaj_q[W-1], dmaj_q});
      end else begin
        err_d = err_sum;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      maj_q       <= '0;
      min_q       <= '0;
      end_q       <= '0;
      dmaj_q      <= '0;
      dmin_q      <= '0;
      err_q       <= '0;
      ystep_neg_q <= 1'b0;
    end else begin
      maj_q       <= maj_d;
      min_q       <= min_d;
      end_q       <= end_d;
      dmaj_q      <= dmaj_d;
      dmin_q      <= dmin_d;
      err_q       <= err_d;
      ystep_neg_q <= ystep_neg_d;
    end
  end

  assign maj    = maj_q;
  assign min    = min_q;
  assign at_end = (maj_q == end_q);

endmodule

// File: rtl/thick_line_rasterizer.sv
// Thick-line rasteriser: walks the Bresenham centre line and emits a clipped
// minor-axis span of Thickness+1 pixels per major step, one pixel per cycle.
module thick_line_rasterizer
  import tlr_pkg::*;
#(
  parameter int XW          = 9,
  parameter int YW          = 8,
  parameter int TW          = 5,
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int PIXEL_BYTES = DEF_PIXEL_BYTES
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          Go,
  input  logic [XW-1:0] X0,
  input  logic [XW-1:0] X1,
  input  logic [YW-1:0] Y0,
  input  logic [YW-1:0] Y1,
  input  logic [TW-1:0] Thickness,
  input  logic          Centered,
  output logic          Done,
  output logic          Draw,
  input  logic          Write_Finish,
  output logic [31:0]   Pixel_Address,
  input  logic [15:0]   Color,
  output logic [15:0]   Pixel_Color,
  input  logic [31:0]   Base_Addr
);

  localparam int W = coord_width(XW, YW);
  localparam logic signed [W-1:0] ONE  = W'(1);
  localparam logic signed [W-1:0] ZERO = '0;

  state_e              state_q, state_d;
  logic [XW-1:0]       x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0]       y0_q, y0_d, y1_q, y1_d;
  logic [TW-1:0]       t_q, t_d;
  logic                centered_q, centered_d, steep_q, steep_d;
  logic [15:0]         color_q, color_d;
  logic [31:0]         base_q, base_d;
  logic signed [W-1:0] off_q, off_d;

  logic signed [W-1:0] ex0, ex1, ey0, ey1, dx, dy, adx, ady;
  logic signed [W-1:0] a0, a1, b0, b1, maj_start, maj_end, min_start, min_end;
  logic signed [W-1:0] t_ext, t_half, off_first, off_last;
  logic signed [W-1:0] maj, min, span_min, px, py;
  logic                steep, load, step, at_end, visible;
  int                  pix_index;

  tlr_bresenham_stepper #(.W(W)) u_stepper (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .step      (step),
    .maj_start (maj_start),
    .maj_end   (maj_end),
    .min_start (min_start),
    .min_end   (min_end),
    .maj       (maj),
    .min       (min),
    .at_end    (at_end)
  );

  // Line setup from the latched endpoints: pick the major axis, order endpoints.
  always_comb begin
    ex0 = $signed({{(W-XW){1'b0}}, x0_q});
    ex1 = $signed({{(W-XW){1'b0}}, x1_q});
    ey0 = $signed({{(W-YW){1'b0}}, y0_q});
    ey1 = $signed({{(W-YW){1'b0}}, y1_q});
    dx  = ex1 - ex0;
    dy  = ey1 - ey0;
    adx = dx[W-1] ? -dx : dx;
    ady = dy[W-1] ? -dy : dy;
    steep = ady > adx;
    a0 = steep ? ey0 : ex0;
    a1 = steep ? ey1 : ex1;
    b0 = steep ? ex0 : ey0;
    b1 = steep ? ex1 : ey1;
    maj_start = (a0 > a1) ? a1 : a0;
    maj_end   = (a0 > a1) ? a0 : a1;
    min_start = (a0 > a1) ? b1 : b0;
    min_end   = (a0 > a1) ? b0 : b1;

    t_ext     = $signed({{(W-TW){1'b0}}, t_q});
    t_half    = t_ext >>> 1;
    off_first = centered_q ? -t_half : ZERO;
    off_last  = centered_q ? (t_ext - t_half) : t_ext;
  end

  always_comb begin
    span_min  = min + off_q;
    px        = steep_q ? span_min : maj;
    py        = steep_q ? maj : span_min;
    visible   = on_screen(int'(px), int'(py), H_RES, V_RES);
    pix_index = int'(py) * H_RES + int'(px);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    t_d        = t_q;
    centered_d = centered_q;
    color_d    = color_q;
    base_d     = base_q;
    steep_d    = steep_q;
    off_d      = off_q;
    load       = 1'b0;
    step       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Go) begin
          x0_d       = X0;
          x1_d       = X1;
          y0_d       = Y0;
          y1_d       = Y1;
          t_d        = Thickness;
          centered_d = Centered;
          color_d    = Color;
          base_d     = Base_Addr;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        load    = 1'b1;
        steep_d = steep;
        off_d   = off_first;
        state_d = S_PIXEL;
      end
      S_PIXEL: begin
        // Clipped pixels advance at once; visible ones wait for the AMC.
        if (!visible || Write_Finish) begin
          if (off_q < off_last) off_d = off_q + ONE;
          else if (at_end)      state_d = S_IDLE;
          else                  state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        step    = 1'b1;
        off_d   = off_first;
        state_d = S_PIXEL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      t_q        <= '0;
      centered_q <= 1'b0;
      color_q    <= '0;
      base_q     <= '0;
      steep_q    <= 1'b0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      t_q        <= t_d;
      centered_q <= centered_d;
      color_q    <= color_d;
      base_q     <= base_d;
      steep_q    <= steep_d;
      off_q      <= off_d;
    end
  end

  assign Done          = (state_q == S_IDLE);
  assign Draw          = (state_q == S_PIXEL) && visible;
  assign Pixel_Address = base_q + $unsigned(pix_index * PIXEL_BYTES);
  assign Pixel_Color   = color_q;

endmodule

// File: tb/tb_thick_line_rasterizer.sv
// Directed bench for thick_line_rasterizer: hand-computed pixel lists, cycle
// counts, clipping, held writes, reset abort and the degenerate single point.
module tb_thick_line_rasterizer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        Go = 1'b0;
  logic [8:0]  X0 = '0, X1 = '0;
  logic [7:0]  Y0 = '0, Y1 = '0;
  logic [4:0]  Thickness = '0;
  logic        Centered = 1'b0;
  logic        Done, Draw;
  logic        Write_Finish = 1'b0;
  logic [31:0] Pixel_Address;
  logic [15:0] Color = '0;
  logic [15:0] Pixel_Color;
  logic [31:0] Base_Addr = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] log_q[$];

  thick_line_rasterizer dut (
    .clk           (clk),
    .resetn        (resetn),
    .Go            (Go),
    .X0            (X0),
    .X1            (X1),
    .Y0            (Y0),
    .Y1            (Y1),
    .Thickness     (Thickness),
    .Centered      (Centered),
    .Done          (Done),
    .Draw          (Draw),
    .Write_Finish  (Write_Finish),
    .Pixel_Address (Pixel_Address),
    .Color         (Color),
    .Pixel_Color   (Pixel_Color),
    .Base_Addr     (Base_Addr)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge, so the negedge value is what the next edge sees.
  always @(negedge clk) if (resetn && Draw && Write_Finish) log_q.push_back(Pixel_Address);

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int x, input int y);
    return base + 32'((y * 320 + x) * 2);
  endfunction

  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int t, input logic c, input logic [31:0] base,
                          output int cycles);
    X0 = 9'(x0); Y0 = 8'(y0); X1 = 9'(x1); Y1 = 8'(y1);
    Thickness = 5'(t); Centered = c; Base_Addr = base;
    Write_Finish = 1'b1;
    log_q.delete();
    Go = 1'b1;
    @(posedge clk); #1;
    Go = 1'b0;
    total++;
    if (Done !== 1'b0) begin
      bad++; $display("FAIL done_after_go: got %b want 0", Done);
    end
    cycles = 0;
    while (!Done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({Done, Draw} !== 2'b10) begin
      bad++; $display("FAIL reset_done_draw: got %b want 10", {Done, Draw});
    end
    total++;
    if (Pixel_Address !== 32'd0 || Pixel_Color !== 16'd0) begin
      bad++; $display("FAIL reset_addr_color: got %h/%h want 0/0", Pixel_Address, Pixel_Color);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_horizontal();
    int cyc;
    Color = 16'hABCD;
    run_line(0, 0, 4, 0, 0, 1'b0, 32'h1000, cyc);
    total++;
    if (cyc !== 10) begin bad++; $display("FAIL horiz_cycles: got %0d want 10", cyc); end
    total++;
    if (log_q.size() !== 5) begin bad++; $display("FAIL horiz_count: got %0d want 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== 32'h1000 + 32'(2 * i)) begin
        bad++; $display("FAIL horiz_addr[%0d]: got %h want %h", i, log_q[i], 32'h1000 + 32'(2 * i));
      end
    end
    Color = 16'h1234;
    @(posedge clk); #1;
    total++;
    if (Pixel_Color !== 16'hABCD) begin
      bad++; $display("FAIL color_latched: got %h want abcd", Pixel_Color);
    end
  endtask

  task automatic test_steep();
    int cyc;
    int ex[15] = '{9,10,11, 9,10,11, 9,10,11, 9,10,11, 9,10,11};
    int ey[15] = '{10,10,10, 11,11,11, 12,12,12, 13,13,13, 14,14,14};
    run_line(10, 10, 10, 14, 2, 1'b1, 32'h0, cyc);
    total++;
    if (cyc !== 20) begin bad++; $display("FAIL steep_cycles: got %0d want 20", cyc); end
    total++;
    if (log_q.size() !== 15) begin bad++; $display("FAIL steep_count: got %0d want 15", log_q.size()); end
    for (int i = 0; i < 15 && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_addr(32'h0, ex[i], ey[i])) begin
        bad++; $display("FAIL steep_addr[%0d]: got %h want %h", i, log_q[i], exp_addr(32'h0, ex[i], ey[i]));
      end
    end
  endtask

  task automatic test_clip_diag();
    int cyc;
    int ex[15] = '{0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3};
    int ey[15] = '{0,1,2, 0,1,2,3, 1,2,3,4, 2,3,4,5};
    run_line(0, 0, 3, 3, 3, 1'b1, 32'h200, cyc);
    total++;
    if (cyc !== 20) begin bad++; $display("FAIL clip_cycles: got %0d want 20", cyc); end
    total++;
    if (log_q.size() !== 15) begin bad++; $display("FAIL clip_count: got %0d want 15", log_q.size()); end
    for (int i = 0; i < 15 && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_addr(32'h200, ex[i], ey[i])) begin
        bad++; $display("FAIL clip_addr[%0d]: got %h want %h", i, log_q[i], exp_addr(32'h200, ex[i], ey[i]));
      end
    end
  endtask

  task automatic test_wf_delay();
    int cyc;
    logic [31:0] want[2];
    want[0] = exp_addr(32'h4000, 318, 5);
    want[1] = exp_addr(32'h4000, 319, 5);
    X0 = 9'd318; Y0 = 8'd5; X1 = 9'd319; Y1 = 8'd5;
    Thickness = '0; Centered = 1'b0; Base_Addr = 32'h4000;
    Write_Finish = 1'b0;
    log_q.delete();
    Go = 1'b1;
    @(posedge clk); #1;
    Go = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cyc = 0;
      while (!Draw && cyc < 10) begin @(posedge clk); #1; cyc++; end
      total++;
      if (Pixel_Address !== want[p]) begin
        bad++; $display("FAIL wf_addr[%0d]: got %h want %h", p, Pixel_Address, want[p]);
      end
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        total++;
        if (Draw !== 1'b1 || Pixel_Address !== want[p]) begin
          bad++; $display("FAIL wf_hold[%0d.%0d]: got draw=%b addr=%h want draw=1 addr=%h",
                          p, k, Draw, Pixel_Address, want[p]);
        end
      end
      Write_Finish = 1'b1;
      @(posedge clk); #1;
      Write_Finish = 1'b0;
    end
    cyc = 0;
    while (!Done && cyc < 10) begin @(posedge clk); #1; cyc++; end
    total++;
    if (Done !== 1'b1) begin bad++; $display("FAIL wf_done: got %b want 1", Done); end
    total++;
    if (log_q.size() !== 2) begin bad++; $display("FAIL wf_count: got %0d want 2", log_q.size()); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic found;
    X0 = 9'd0; Y0 = 8'd0; X1 = 9'd4; Y1 = 8'd0;
    Thickness = '0; Centered = 1'b0; Base_Addr = 32'h800;
    Write_Finish = 1'b1;
    Go = 1'b1;
    @(posedge clk); #1;
    Go = 1'b0;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 20) begin
      if (Draw && Pixel_Address == exp_addr(32'h800, 2, 0)) found = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL abort_third_pixel: got none want addr %h", exp_addr(32'h800, 2, 0)); end
    resetn = 1'b0;
    #1;
    total++;
    if ({Done, Draw} !== 2'b10) begin
      bad++; $display("FAIL abort_immediate: got done,draw=%b want 10", {Done, Draw});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_line(0, 0, 4, 0, 0, 1'b0, 32'h800, cyc);
    total++;
    if (cyc !== 10 || log_q.size() !== 5) begin
      bad++; $display("FAIL abort_redraw: got cycles=%0d writes=%0d want 10/5", cyc, log_q.size());
    end
    total++;
    if (log_q.size() == 5 && log_q[4] !== exp_addr(32'h800, 4, 0)) begin
      bad++; $display("FAIL abort_last_addr: got %h want %h", log_q[4], exp_addr(32'h800, 4, 0));
    end
  endtask

  task automatic test_degenerate();
    int cyc;
    run_line(7, 7, 7, 7, 1, 1'b0, 32'h0, cyc);
    total++;
    if (cyc !== 3) begin bad++; $display("FAIL point_cycles: got %0d want 3", cyc); end
    total++;
    if (log_q.size() !== 2) begin bad++; $display("FAIL point_count: got %0d want 2", log_q.size()); end
    else begin
      total++;
      if (log_q[0] !== exp_addr(32'h0, 7, 7) || log_q[1] !== exp_addr(32'h0, 7, 8)) begin
        bad++; $display("FAIL point_addr: got %h,%h want %h,%h", log_q[0], log_q[1],
                        exp_addr(32'h0, 7, 7), exp_addr(32'h0, 7, 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_clip_diag();
    test_wf_delay();
    test_reset_abort();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
